sram_bus_arbiter: RTL

- Shares one sram-like memory port (req/addr_ok/data_ok handshake) between the fetch stage (inst master, read-only) and the memory stage (data master, read/write).
- Sits between the pipeline and the future AXI bridge.
- Fixed priority: data over inst, with an anti-starvation counter for inst.
- Tracks outstanding transactions in order, so each data_ok returns to the master that issued it.

---
 rtl/sram_bus_arbiter_pkg.sv | 27 ++
 rtl/sram_bus_arbiter_owner_fifo.sv | 60 ++++++
 rtl/sram_bus_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types and constants for the sram-like bus arbiter.
// Owner encoding, access size and the request bundle layout.
package sram_bus_arbiter_pkg;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_e;

    typedef enum logic {
        LK_FREE = 1'b0,
        LK_HELD = 1'b1
    } lock_e;

    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_cmd_t;

    localparam int ARB_BUS_W = $bits(mem_cmd_t);

endpackage

// File: rtl/sram_bus_arbiter_owner_fifo.sv
// In-order record of which master owns each outstanding transaction.
// Depth must be a power of two so the pointers wrap naturally.
module sram_bus_arbiter_owner_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       push_owner,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic                       head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] slots;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = slots[rd_ptr];

    // Owner storage; contents are meaningless while empty so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= push_owner;
        end
    end

    // Pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one sram-like port between fetch (inst) and memory (data).
// Data wins, inst is forced after STARVE_MAX consecutive data wins.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int STARVE_MAX  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        resp_err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int CW = $clog2(OUTSTANDING + 1);

    lock_e    lock_state;
    lock_e    lock_next;
    owner_e   lock_owner;
    owner_e   lock_owner_next;
    owner_e   owner;
    owner_e   head_owner;
    logic     grant;
    logic     accept;
    logic     starve_hit;
    logic     fifo_full;
    logic     fifo_empty;
    logic     fifo_head;
    logic     resp_valid;
    logic [CW-1:0] fifo_count;
    logic [SW-1:0] starve_cnt;
    mem_cmd_t inst_cmd;
    mem_cmd_t data_cmd;
    mem_cmd_t mem_cmd;

    assign starve_hit = inst_req && (starve_cnt == SW'(STARVE_MAX));

    assign inst_cmd = '{wr: 1'b0, size: SIZE_WORD, wstrb: 4'b0000,
                        addr: inst_addr, wdata: 32'h0};
    assign data_cmd = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                        addr: data_addr, wdata: data_wdata};

    // Pick the owner: a held lock overrides priority, else fixed order.
    always_comb begin
        grant = 1'b0;
        owner = OWNER_INST;
        if (lock_state == LK_HELD) begin
            grant = 1'b1;
            owner = lock_owner;
        end else if (fifo_full) begin
            grant = 1'b0;
        end else if (data_req && !starve_hit) begin
            grant = 1'b1;
            owner = OWNER_DATA;
        end else if (inst_req) begin
            grant = 1'b1;
            owner = OWNER_INST;
        end
    end

    // Drive the memory port from the granted master, zero when idle.
    always_comb begin
        mem_cmd = '0;
        if (grant) begin
            mem_cmd = (owner == OWNER_DATA) ? data_cmd : inst_cmd;
        end
    end

    assign mem_req   = grant;
    assign mem_wr    = mem_cmd.wr;
    assign mem_size  = mem_cmd.size;
    assign mem_wstrb = mem_cmd.wstrb;
    assign mem_addr  = mem_cmd.addr;
    assign mem_wdata = mem_cmd.wdata;

    assign accept       = grant && mem_addr_ok;
    assign inst_addr_ok = accept && (owner == OWNER_INST);
    assign data_addr_ok = accept && (owner == OWNER_DATA);

    assign head_owner   = owner_e'(fifo_head);
    assign resp_valid   = mem_data_ok && !fifo_empty;
    assign inst_data_ok = resp_valid && (head_owner == OWNER_INST);
    assign data_data_ok = resp_valid && (head_owner == OWNER_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    // Lock register: holds the owner of a request the memory stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_state <= LK_FREE;
            lock_owner <= OWNER_INST;
        end else begin
            lock_state <= lock_next;
            lock_owner <= lock_owner_next;
        end
    end

    // Lock next state: take on a stalled grant, release on accept.
    always_comb begin
        lock_next       = lock_state;
        lock_owner_next = lock_owner;
        unique case (lock_state)
            LK_FREE: begin
                if (grant && !mem_addr_ok) begin
                    lock_next       = LK_HELD;
                    lock_owner_next = owner;
                end
            end
            LK_HELD: begin
                if (mem_addr_ok) begin
                    lock_next = LK_FREE;
                end
            end
            default: lock_next = LK_FREE;
        endcase
    end

    // Count data wins while inst is waiting; any inst win or idle clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!inst_req) begin
            starve_cnt <= '0;
        end else if (accept && owner == OWNER_INST) begin
            starve_cnt <= '0;
        end else if (accept && starve_cnt != SW'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Sticky flag for a response with nothing outstanding.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_err <= 1'b0;
        end else if (mem_data_ok && fifo_empty) begin
            resp_err <= 1'b1;
        end
    end

    sram_bus_arbiter_owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (accept),
        .push_owner (logic'(owner)),
        .pop        (mem_data_ok),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (fifo_head),
        .count      (fifo_count)
    );

    logic unused_ok;
    assign unused_ok = ^fifo_count;

endmodule
